// File: rtl/dbg_char_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dbg_char_pkg
// Description : Shared types and constants for the debug character transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package dbg_char_pkg;

    // Transmit sequencer phases
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_e;

    // Plain-vector aliases of the phases for the state register
    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_SETUP  = SETUP;
    localparam logic [1:0] ST_STROBE = STROBE;
    localparam logic [1:0] ST_HOLD   = HOLD;

    // Byte value that tells the bench-side monitor the test is over
    localparam logic [7:0] EOT_CHAR = 8'h04;

    // Largest of three phase lengths; sizes the shared pacing counter
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dbg_char_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dbg_char_fifo
// Description : DEPTH x 8 byte queue. Pointers carry one extra MSB so that
//               full and empty stay distinguishable after wrap-around.
//               Status and read data come straight from registers; a byte
//               written this cycle is never visible on pop_data until next.
// Revision    : 1.0 - initial release
// ============================================================================
module dbg_char_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     resetb,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_do_push;
    logic        w_do_pop;

    // Same index with differing wrap bits means the writer lapped the reader
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign count     = r_wr_ptr - r_rd_ptr;
    assign pop_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage array; contents need no reset since empty gates every read
    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Pointer advance; reset discards anything still queued
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dbg_char_tx.sv
`default_nettype none
// ============================================================================
// Module      : dbg_char_tx
// Description : Debug character transmitter. Queues bytes and presents each
//               on io_data with a paced strobe: data settles SETUP_CYC cycles
//               before the rising edge, strobe stays high STROBE_CYC cycles,
//               and data is held HOLD_CYC cycles after the falling edge.
//               Sending the end-of-test byte latches eot_sent until reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dbg_char_tx #(
    parameter int DEPTH      = 8,
    parameter int SETUP_CYC  = 4,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 4
) (
    input  logic       clock,
    input  logic       resetb,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] io_data,
    output logic [7:0] io_oeb,
    output logic       strobe,
    output logic       busy,
    output logic       eot_sent
);

    import dbg_char_pkg::*;

    localparam int CNT_W = $clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC)) + 1;
    localparam logic [CNT_W-1:0] c_setup_load  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] c_strobe_load = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] c_hold_load   = CNT_W'(HOLD_CYC - 1);

    logic [1:0]             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [7:0]             r_io_data;
    logic [7:0]             r_io_oeb;
    logic                   r_strobe;
    logic                   r_eot_sent;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [7:0]             w_head;
    logic [$clog2(DEPTH):0] w_count;

    // Once end-of-test is latched the port refuses further bytes
    assign in_ready = !w_full && !r_eot_sent;
    assign w_push   = in_valid && in_ready;
    // A byte is taken either from idle or at the very end of a hold phase
    assign w_pop    = !w_empty &&
                      ((r_state == ST_IDLE) ||
                       ((r_state == ST_HOLD) && (r_cnt == '0)));

    assign io_data  = r_io_data;
    assign io_oeb   = r_io_oeb;
    assign strobe   = r_strobe;
    assign eot_sent = r_eot_sent;
    assign busy     = (w_count != '0) || (r_state != ST_IDLE);

    dbg_char_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .resetb    (resetb),
        .push      (w_push),
        .push_data (in_data),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    // Phase sequencer with shared down-counter, output registers and eot latch
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_io_data  <= 8'h00;
            r_io_oeb   <= 8'hFF;
            r_strobe   <= 1'b0;
            r_eot_sent <= 1'b0;
        end else begin
            r_io_oeb <= 8'h00;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_io_data <= w_head;
                        r_cnt     <= c_setup_load;
                        r_state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == '0) begin
                        r_strobe <= 1'b1;
                        r_cnt    <= c_strobe_load;
                        r_state  <= ST_STROBE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_STROBE: begin
                    if (r_cnt == '0) begin
                        r_strobe <= 1'b0;
                        r_cnt    <= c_hold_load;
                        r_state  <= ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    if (r_cnt == '0) begin
                        if (r_io_data == EOT_CHAR) begin
                            r_eot_sent <= 1'b1;
                        end
                        if (w_pop) begin
                            r_io_data <= w_head;
                            r_cnt     <= c_setup_load;
                            r_state   <= ST_SETUP;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dbg_char_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_dbg_char_tx
// Description : Self-checking bench for dbg_char_tx. A default instance and a
//               minimum-timing (1/1/1, DEPTH=2) instance are exercised.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dbg_char_tx;

    logic       clock = 1'b0;
    logic       resetb, in_valid, in_ready, strobe, busy, eot_sent;
    logic [7:0] in_data, io_data, io_oeb;
    logic       resetb2, in_valid2, in_ready2, strobe2, busy2, eot_sent2;
    logic [7:0] in_data2, io_data2, io_oeb2;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q  [$];
    logic [7:0] exp_q2 [$];
    int         rise_cyc  [$];
    logic [7:0] rise_dat  [$];
    int         rise2_cyc [$];

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       e_strobe;
        logic [7:0] e_io;
        logic       e_busy;
        logic       e_eot;
        logic       e_ready;
    } vec_t;

    vec_t vec [16];

    always #5 clock = ~clock;

    dbg_char_tx dut (
        .clock    (clock),
        .resetb   (resetb),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .io_data  (io_data),
        .io_oeb   (io_oeb),
        .strobe   (strobe),
        .busy     (busy),
        .eot_sent (eot_sent)
    );

    dbg_char_tx #(
        .DEPTH      (2),
        .SETUP_CYC  (1),
        .STROBE_CYC (1),
        .HOLD_CYC   (1)
    ) dut2 (
        .clock    (clock),
        .resetb   (resetb2),
        .in_valid (in_valid2),
        .in_data  (in_data2),
        .in_ready (in_ready2),
        .io_data  (io_data2),
        .io_oeb   (io_oeb2),
        .strobe   (strobe2),
        .busy     (busy2),
        .eot_sent (eot_sent2)
    );

    task automatic chk(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [7:0] d,
                                input logic s, input logic [7:0] io, input logic b);
        vec_t r;
        r.valid = v; r.data = d; r.e_strobe = s; r.e_io = io;
        r.e_busy = b; r.e_eot = 1'b0; r.e_ready = 1'b1;
        return r;
    endfunction

    // Offer one byte to the default instance; returns cycles spent waiting
    task automatic push(input logic [7:0] b, output int waited);
        waited   = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && waited < 300) begin
            @(negedge clock);
            waited++;
        end
        chk(in_ready === 1'b1, "push_accept_timeout", in_ready, 1);
        if (in_ready) begin
            exp_q.push_back(b);
            @(negedge clock);
        end
        in_valid = 1'b0;
    endtask

    task automatic push2(input logic [7:0] b);
        int waited = 0;
        in_valid2 = 1'b1;
        in_data2  = b;
        while (!in_ready2 && waited < 300) begin
            @(negedge clock);
            waited++;
        end
        chk(in_ready2 === 1'b1, "push2_accept_timeout", in_ready2, 1);
        if (in_ready2) begin
            exp_q2.push_back(b);
            @(negedge clock);
        end
        in_valid2 = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk(busy === 1'b0, name, busy, 0);
    endtask

    // Reference monitor, default instance: scoreboard order plus timing windows
    initial begin
        int         cyc, last_chg, fall_cyc;
        bit         fall_pend, prev_stb;
        logic [7:0] prev_dat, e;
        cyc = 0; last_chg = 0; fall_cyc = 0; fall_pend = 0; prev_stb = 0; prev_dat = 0;
        forever begin
            @(negedge clock);
            cyc++;
            if (!resetb) begin
                prev_stb = 0; prev_dat = io_data; fall_pend = 0; last_chg = cyc;
            end else begin
                if (io_data !== prev_dat) begin
                    if (fall_pend) chk(cyc - fall_cyc >= 4, "hold_window", cyc - fall_cyc, 4);
                    fall_pend = 0;
                    last_chg  = cyc;
                end
                if (strobe && !prev_stb) begin
                    chk(cyc - last_chg >= 4, "setup_window", cyc - last_chg, 4);
                    rise_cyc.push_back(cyc);
                    rise_dat.push_back(io_data);
                    chk(exp_q.size() != 0, "sb_unexpected_byte", io_data, 0);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk(io_data === e, "sb_byte", io_data, e);
                    end
                end
                if (!strobe && prev_stb) begin
                    fall_pend = 1;
                    fall_cyc  = cyc;
                end
                prev_stb = strobe;
                prev_dat = io_data;
            end
        end
    end

    // Reference monitor, minimum-timing instance
    initial begin
        int         cyc, last_chg, fall_cyc;
        bit         fall_pend, prev_stb;
        logic [7:0] prev_dat, e;
        cyc = 0; last_chg = 0; fall_cyc = 0; fall_pend = 0; prev_stb = 0; prev_dat = 0;
        forever begin
            @(negedge clock);
            cyc++;
            if (!resetb2) begin
                prev_stb = 0; prev_dat = io_data2; fall_pend = 0; last_chg = cyc;
            end else begin
                if (io_data2 !== prev_dat) begin
                    if (fall_pend) chk(cyc - fall_cyc >= 1, "hold_window2", cyc - fall_cyc, 1);
                    fall_pend = 0;
                    last_chg  = cyc;
                end
                if (strobe2 && !prev_stb) begin
                    chk(cyc - last_chg >= 1, "setup_window2", cyc - last_chg, 1);
                    rise2_cyc.push_back(cyc);
                    chk(exp_q2.size() != 0, "sb2_unexpected_byte", io_data2, 0);
                    if (exp_q2.size() != 0) begin
                        e = exp_q2.pop_front();
                        chk(io_data2 === e, "sb2_byte", io_data2, e);
                    end
                end
                if (!strobe2 && prev_stb) begin
                    fall_pend = 1;
                    fall_cyc  = cyc;
                end
                prev_stb = strobe2;
                prev_dat = io_data2;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         w, n_rise;
        logic [7:0] b;
        logic [11:0] act, req;

        // Test 1 vectors: a single 8'h41 through default timing
        vec[0] = mk(1'b1, 8'h41, 1'b0, 8'h00, 1'b0);
        vec[1] = mk(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        for (int i = 2;  i <= 5;  i++) vec[i] = mk(1'b0, 8'h00, 1'b0, 8'h41, 1'b1);
        for (int i = 6;  i <= 9;  i++) vec[i] = mk(1'b0, 8'h00, 1'b1, 8'h41, 1'b1);
        for (int i = 10; i <= 13; i++) vec[i] = mk(1'b0, 8'h00, 1'b0, 8'h41, 1'b1);
        for (int i = 14; i <= 15; i++) vec[i] = mk(1'b0, 8'h00, 1'b0, 8'h41, 1'b0);

        resetb = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        resetb2 = 1'b0; in_valid2 = 1'b0; in_data2 = 8'h00;
        repeat (2) @(negedge clock);
        chk(io_oeb === 8'hFF, "rst_io_oeb", io_oeb, 8'hFF);
        chk(io_data === 8'h00, "rst_io_data", io_data, 0);
        chk({strobe, busy, eot_sent} === 3'b000, "rst_strobe_busy_eot", {strobe, busy, eot_sent}, 0);
        chk(in_ready === 1'b1, "rst_in_ready", in_ready, 1);
        resetb = 1'b1; resetb2 = 1'b1;
        @(negedge clock);
        chk(io_oeb === 8'h00, "oeb_after_release", io_oeb, 8'h00);

        // Test 1: cycle-by-cycle table
        for (int i = 0; i < 16; i++) begin
            act = {strobe, io_data, busy, eot_sent, in_ready};
            req = {vec[i].e_strobe, vec[i].e_io, vec[i].e_busy, vec[i].e_eot, vec[i].e_ready};
            chk(act === req, $sformatf("t1_vec%0d", i), act, req);
            in_valid = vec[i].valid;
            in_data  = vec[i].data;
            if (vec[i].valid) exp_q.push_back(vec[i].data);
            @(negedge clock);
        end

        // Test 2: "ABC" back to back, rises 12 cycles apart
        rise_cyc.delete(); rise_dat.delete();
        push(8'h41, w); push(8'h42, w); push(8'h43, w);
        wait_idle(300, "t2_idle_timeout");
        chk(rise_cyc.size() == 3, "t2_rise_count", rise_cyc.size(), 3);
        if (rise_cyc.size() == 3) begin
            chk({rise_dat[0], rise_dat[1], rise_dat[2]} === 24'h414243, "t2_sequence",
                {rise_dat[0], rise_dat[1], rise_dat[2]}, 24'h414243);
            chk(rise_cyc[1] - rise_cyc[0] == 12, "t2_gap_ab", rise_cyc[1] - rise_cyc[0], 12);
            chk(rise_cyc[2] - rise_cyc[1] == 12, "t2_gap_bc", rise_cyc[2] - rise_cyc[1], 12);
        end

        // Test 3: fill while a lead byte is in flight, 9th byte back-pressured
        push(8'h30, w);
        @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            push(8'h31 + 8'(i), w);
            chk(w == 0, $sformatf("t3_no_wait_%0d", i), w, 0);
        end
        chk(in_ready === 1'b0, "t3_full_ready", in_ready, 0);
        push(8'h39, w);
        chk(w > 0, "t3_ninth_delayed", w, 1);
        wait_idle(500, "t3_idle_timeout");
        chk(exp_q.size() == 0, "t3_all_sent", exp_q.size(), 0);

        // Randomized traffic with random gaps
        for (int i = 0; i < 30; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'h04) b = 8'h05;
            push(b, w);
            repeat ($urandom_range(0, 15)) @(negedge clock);
        end
        wait_idle(1000, "rand_idle_timeout");
        chk(exp_q.size() == 0, "rand_all_sent", exp_q.size(), 0);
        chk(eot_sent === 1'b0, "rand_no_eot", eot_sent, 0);

        // Test 4: end-of-test byte followed by an already-queued byte
        push(8'h58, w); push(8'h04, w); push(8'h59, w);
        w = 0;
        while (!(strobe && io_data == 8'h04) && w < 300) begin
            @(negedge clock);
            w++;
        end
        chk(strobe === 1'b1 && io_data === 8'h04, "t4_eot_strobe_seen", io_data, 8'h04);
        w = 0;
        while (strobe && w < 20) begin
            @(negedge clock);
            w++;
        end
        chk(eot_sent === 1'b0, "t4_eot_at_fall", eot_sent, 0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clock);
            chk(eot_sent === 1'b0, $sformatf("t4_eot_hold%0d", i), eot_sent, 0);
        end
        @(negedge clock);
        chk(eot_sent === 1'b1, "t4_eot_set", eot_sent, 1);
        chk(io_data === 8'h59, "t4_next_popped", io_data, 8'h59);
        chk(in_ready === 1'b0, "t4_ready_after_eot", in_ready, 0);
        wait_idle(300, "t4_idle_timeout");
        chk(exp_q.size() == 0, "t4_all_sent", exp_q.size(), 0);
        n_rise = rise_cyc.size();
        in_valid = 1'b1; in_data = 8'h5A;
        repeat (20) @(negedge clock);
        chk(in_ready === 1'b0, "t4_push_refused", in_ready, 0);
        in_valid = 1'b0;
        chk(busy === 1'b0 && rise_cyc.size() == n_rise, "t4_no_extra_send",
            rise_cyc.size(), n_rise);
        chk(eot_sent === 1'b1, "t4_eot_sticky", eot_sent, 1);

        // Test 5: reset during a strobe with more bytes queued
        resetb = 1'b0;
        repeat (2) @(negedge clock);
        resetb = 1'b1;
        @(negedge clock);
        chk(eot_sent === 1'b0 && in_ready === 1'b1, "t5_eot_cleared", eot_sent, 0);
        push(8'h61, w); push(8'h62, w); push(8'h63, w); push(8'h64, w);
        w = 0;
        while (!strobe && w < 100) begin
            @(negedge clock);
            w++;
        end
        chk(strobe === 1'b1, "t5_strobe_seen", strobe, 1);
        #2;
        resetb = 1'b0;
        #1;
        chk(strobe === 1'b0, "t5_strobe_drop", strobe, 0);
        chk(io_oeb === 8'hFF, "t5_oeb_drop", io_oeb, 8'hFF);
        chk(busy === 1'b0, "t5_fifo_flushed", busy, 0);
        exp_q.delete();
        n_rise = rise_cyc.size();
        repeat (2) @(negedge clock);
        resetb = 1'b1;
        repeat (60) @(negedge clock);
        chk(busy === 1'b0, "t5_busy_after", busy, 0);
        chk(rise_cyc.size() == n_rise, "t5_no_strobes", rise_cyc.size(), n_rise);
        chk(io_oeb === 8'h00, "t5_oeb_after", io_oeb, 8'h00);

        // Test 6: minimum timing, DEPTH=2, continuous random stream of 20
        rise2_cyc.delete();
        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'h04) b = 8'h44;
            push2(b);
        end
        w = 0;
        while (busy2 && w < 200) begin
            @(negedge clock);
            w++;
        end
        chk(busy2 === 1'b0, "t6_idle_timeout", busy2, 0);
        chk(rise2_cyc.size() == 20, "t6_rise_count", rise2_cyc.size(), 20);
        for (int i = 1; i < rise2_cyc.size(); i++) begin
            chk(rise2_cyc[i] - rise2_cyc[i-1] == 3, $sformatf("t6_gap%0d", i),
                rise2_cyc[i] - rise2_cyc[i-1], 3);
        end
        chk(exp_q2.size() == 0, "t6_all_sent", exp_q2.size(), 0);
        chk(io_oeb2 === 8'h00 && eot_sent2 === 1'b0, "t6_oeb_eot", {io_oeb2, eot_sent2}, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
